// File: rtl/rob_pkg.sv
// Shared types and helpers for the rob_multi reorder buffer.
// Optional macros: FIFO_DATA_WIDTH and AXI_ID_WIDTH set the default widths.
`ifndef FIFO_DATA_WIDTH
`define FIFO_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package rob_pkg;

    localparam int ROB_DEPTH   = 8;
    localparam int SLOT_IDX_W  = $clog2(ROB_DEPTH);
    localparam int SLOT_DATA_W = `FIFO_DATA_WIDTH;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } out_state_t;

    typedef struct packed {
        logic                   vld;
        logic [SLOT_DATA_W-1:0] data;
    } slot_t;

    // Distance of tid ahead of head, modulo 2^id_w.
    function automatic logic [31:0] tid_dist(
        input logic [31:0] tid,
        input logic [31:0] head,
        input int unsigned id_w
    );
        logic [31:0] mask;
        mask = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
        return (tid - head) & mask;
    endfunction

endpackage

// File: rtl/rob_slot_array.sv
// Tid-indexed slot storage for rob_multi.
// Ports: NUM_SRC write ports (wr_en/wr_idx/wr_data), one read port
// (rd_idx -> rd_data), one clear port (clr_en/clr_idx), vld bitmap out.
module rob_slot_array
    import rob_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 2,
    parameter int IDX_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            wr_en,
    input  logic [NUM_SRC*IDX_W-1:0]      wr_idx,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] wr_data,
    input  logic                          clr_en,
    input  logic [IDX_W-1:0]              clr_idx,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [DEPTH-1:0]              vld,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t mem [DEPTH];

    // Writers always target distinct empty slots and the clear port
    // always targets a full one, so no two updates hit the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                mem[clr_idx].vld <= 1'b0;
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (wr_en[s]) begin
                    mem[wr_idx[s*IDX_W +: IDX_W]].vld  <= 1'b1;
                    mem[wr_idx[s*IDX_W +: IDX_W]].data <=
                        wr_data[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = mem[i].vld;
        end
    end

    assign rd_data = mem[rd_idx].data;

endmodule

// File: rtl/rob_multi.sv
// In-order reorder buffer merging NUM_SRC out-of-order response streams.
// Ports: src_valid_i/src_ready_o/src_tid_i/src_data_i per source (packed,
// source 0 in LSBs and highest priority); valid_o/ready_i/rid_o/rdata_o
// in-order output; count_o = occupied slots. Macro: ROB_BYPASS_EN.
module rob_multi
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = `FIFO_DATA_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH,
    parameter int DEPTH      = 8,
    parameter int NUM_SRC    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    output logic [NUM_SRC-1:0]            src_ready_o,
    input  logic [NUM_SRC*ID_WIDTH-1:0]   src_tid_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [ID_WIDTH-1:0]           rid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = IDX_W + 1;

    logic [ID_WIDTH-1:0]    head;
    logic [IDX_W-1:0]       head_idx;
    logic [DEPTH-1:0]       slot_vld;
    logic [DATA_WIDTH-1:0]  head_data;

    out_state_t             state;
    out_state_t             state_nx;
    logic                   out_vld;
    logic [ID_WIDTH-1:0]    rid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [CW-1:0]          count_q;

    logic [ID_WIDTH-1:0]    tid_a [NUM_SRC];
    logic [IDX_W-1:0]       idx_a [NUM_SRC];
    logic [NUM_SRC*IDX_W-1:0] src_idx;
    logic [NUM_SRC-1:0]     win_ok;
    logic [NUM_SRC-1:0]     src_rdy;
    logic [NUM_SRC-1:0]     acc;
    logic [NUM_SRC-1:0]     byp_vec;
    logic [NUM_SRC-1:0]     slot_we;

    logic                   out_free;
    logic                   load;
    logic                   bypass;
    logic                   take;
    logic [DATA_WIDTH-1:0]  take_data;
    logic [CW-1:0]          n_wr;

    assign head_idx = head[IDX_W-1:0];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign tid_a[g] = src_tid_i[g*ID_WIDTH +: ID_WIDTH];
        assign idx_a[g] = tid_a[g][IDX_W-1:0];
        assign src_idx[g*IDX_W +: IDX_W] = idx_a[g];
        assign win_ok[g] =
            tid_dist(32'(tid_a[g]), 32'(head), ID_WIDTH) < 32'(DEPTH);
    end

    // A lower source only blocks when its tid is in the window: two
    // distinct in-window tids never share an index, and an out-of-window
    // (stalled) source must not starve a higher-index one.
    always_comb begin
        src_rdy = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_rdy[s] = !rst && win_ok[s] && !slot_vld[idx_a[s]];
            for (int j = 0; j < s; j++) begin
                if (win_ok[j] && (idx_a[j] == idx_a[s])) begin
                    src_rdy[s] = 1'b0;
                end
            end
        end
    end

    assign acc      = src_valid_i & src_rdy;
    assign out_free = !out_vld || ready_i;
    assign load     = slot_vld[head_idx] && out_free;

`ifdef ROB_BYPASS_EN
    always_comb begin
        byp_vec = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            byp_vec[s] = acc[s] && (tid_a[s] == head)
                      && !slot_vld[head_idx] && out_free;
        end
    end

    always_comb begin
        take_data = head_data;
        if (!load) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (byp_vec[s]) begin
                    take_data = src_data_i[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
`else
    assign byp_vec   = '0;
    assign take_data = head_data;
`endif

    assign bypass  = |byp_vec;
    assign take    = load || bypass;
    assign slot_we = acc & ~byp_vec;

    always_comb begin
        n_wr = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            n_wr = n_wr + CW'(slot_we[s]);
        end
    end

    rob_slot_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC),
        .IDX_W      (IDX_W)
    ) u_slots (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (slot_we),
        .wr_idx  (src_idx),
        .wr_data (src_data_i),
        .clr_en  (load),
        .clr_idx (head_idx),
        .rd_idx  (head_idx),
        .vld     (slot_vld),
        .rd_data (head_data)
    );

    always_comb begin
        state_nx = state;
        out_vld  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (take) state_nx = S_VALID;
            end
            S_VALID: begin
                out_vld = 1'b1;
                if (ready_i && !take) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            head    <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            count_q <= count_q + n_wr - CW'(load);
            if (take) begin
                head    <= head + 1'b1;
                rid_q   <= head;
                rdata_q <= take_data;
            end
        end
    end

    assign src_ready_o = src_rdy;
    assign valid_o     = out_vld;
    assign rid_o       = rid_q;
    assign rdata_o     = rdata_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard testbench for rob_multi (DEPTH=8, ID_WIDTH=4, two sources).
// Expectations are queued in tid order; a negedge monitor checks outputs.
module tb_rob_multi;

    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int DEP = 8;
    localparam int NS  = 2;
`ifdef ROB_BYPASS_EN
    localparam int LAT  = 0;
    localparam int PEAK = 3;
`else
    localparam int LAT  = 1;
    localparam int PEAK = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*IW-1:0]  src_tid;
    logic [NS*DW-1:0]  src_data;
    logic              valid_o;
    logic              ready_i;
    logic [IW-1:0]     rid_o;
    logic [DW-1:0]     rdata_o;
    logic [$clog2(DEP):0] count_o;

    typedef struct {
        logic [IW-1:0] rid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   fire_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   peak = 0;
    int   last_acc = 0;
    bit   hold_v = 0;
    logic [IW-1:0] hold_rid;
    logic [DW-1:0] hold_data;

    rob_multi #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEP),
        .NUM_SRC    (NS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .src_tid_i   (src_tid),
        .src_data_i  (src_data),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .rid_o       (rid_o),
        .rdata_o     (rdata_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] dat(int t, int tag);
        return 32'hA500_0000 | (32'(tag) << 8) | 32'(t & 15);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_t(int t, int tag);
        exp_t x;
        x.rid  = 4'(t);
        x.data = dat(t, tag);
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (hold_v && valid_o) begin
            chk("hold_rid", 32'(rid_o), 32'(hold_rid));
            chk("hold_data", rdata_o, hold_data);
        end
        hold_v    = valid_o && !ready_i;
        hold_rid  = rid_o;
        hold_data = rdata_o;
        if (valid_o && ready_i) begin
            fire_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: rid %0d with empty queue",
                         rid_o);
            end else begin
                e = exp_q.pop_front();
                chk("out_rid", 32'(rid_o), 32'(e.rid));
                chk("out_data", rdata_o, e.data);
            end
        end
        if (int'(count_o) > peak) peak = int'(count_o);
    end

    task automatic send(int s, int t, int tag);
        int n;
        bit ok;
        for (int k = 0; k < NS; k++) begin
            src_valid[k] = 1'b0;
            src_tid[k*IW +: IW] = 4'(t ^ 8);
        end
        src_valid[s] = 1'b1;
        src_tid[s*IW +: IW] = 4'(t);
        src_data[s*DW +: DW] = dat(t, tag);
        ok = 0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = src_ready[s];
            @(posedge clk);
            #1;
            n++;
        end
        src_valid[s] = 1'b0;
        last_acc = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tid %0d src %0d not accepted", t, s);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_fires(string nm, int first, int num);
        chk({nm, "_fires"}, 32'(fire_q.size()), 32'(num));
        for (int i = 0; i < num && i < fire_q.size(); i++) begin
            chk({nm, "_cyc"}, 32'(fire_q[i]), 32'(first + i));
        end
    endtask

    initial begin
        int a;
        bit r;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        bit r;
        rst       = 1'b1;
        ready_i   = 1'b1;
        src_valid = '0;
        src_tid   = '0;
        src_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        src_valid[0] = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_rid", 32'(rid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        src_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // In-order, back-to-back from source 0.
        fire_q.delete();
        for (int t = 0; t < 8; t++) expect_t(t, 1);
        a = 0;
        for (int t = 0; t < 8; t++) begin
            send(0, t, 1);
            if (t == 0) a = last_acc;
        end
        drain();
        chk_fires("inorder", a + LAT, 8);

        // Reverse order from source 1 (tids 11..8).
        fire_q.delete();
        peak = 0;
        for (int t = 8; t < 12; t++) expect_t(t, 2);
        send(1, 11, 2);
        chk("rev_hold11", 32'(valid_o), 32'd0);
        send(1, 10, 2);
        chk("rev_hold10", 32'(valid_o), 32'd0);
        send(1, 9, 2);
        chk("rev_hold9", 32'(valid_o), 32'd0);
        send(1, 8, 2);
        a = last_acc;
        drain();
        chk("rev_peak", 32'(peak), 32'(PEAK));
        chk_fires("rev", a + LAT, 4);

        // Window: head=12, source 0 offers tid 4 (= head + DEPTH).
        fire_q.delete();
        for (int t = 12; t < 16; t++) expect_t(t, 3);
        for (int t = 0; t < 5; t++) expect_t(t, 3);
        src_valid[0] = 1'b1;
        src_tid[0 +: IW] = 4'd4;
        src_data[0 +: DW] = dat(4, 3);
        src_tid[IW +: IW] = 4'd12;
        src_data[DW +: DW] = dat(12, 3);
        repeat (3) begin
            @(negedge clk);
            chk("win_stall", 32'(src_ready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        src_valid[1] = 1'b1;
        @(negedge clk);
        chk("win_rdy1", 32'(src_ready[1]), 32'd1);
        chk("win_stall0", 32'(src_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        src_valid[1] = 1'b0;
        @(negedge clk);
        r = src_ready[0];
        chk("win_rise_a", 32'(r), 32'(LAT == 0));
        @(posedge clk);
        #1;
        if (!r) begin
            @(negedge clk);
            chk("win_rise_b", 32'(src_ready[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        src_valid[0] = 1'b0;
        for (int t = 13; t < 20; t++) send(1, t & 15, 3);
        drain();

        // Conflict on tid 5, then backpressure.
        fire_q.delete();
        for (int t = 5; t < 8; t++) expect_t(t, 4);
        ready_i = 1'b0;
        src_valid = 2'b11;
        src_tid = {4'd5, 4'd5};
        src_data = {dat(5, 9), dat(5, 4)};
        @(negedge clk);
        chk("cfl_rdy0", 32'(src_ready[0]), 32'd1);
        chk("cfl_rdy1", 32'(src_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        src_valid = '0;
        send(0, 6, 4);
        send(1, 7, 4);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid_o), 32'd1);
            chk("bp_rid", 32'(rid_o), 32'd5);
            chk("bp_data", rdata_o, dat(5, 4));
            @(posedge clk);
            #1;
        end
        chk("bp_count", 32'(count_o), 32'd2);
        ready_i = 1'b1;
        drain();

        // Reset with the output stage and five slots occupied.
        ready_i = 1'b0;
        send(0, 8, 5);
        for (int t = 9; t < 14; t++) send(t % 2, t, 5);
        chk("pre_rst_count", 32'(count_o), 32'd5);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        src_valid[0] = 1'b1;
        src_tid[0 +: IW] = 4'd14;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_ready", 32'(src_ready), 32'd0);
        src_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_i = 1'b1;

        // Wrap: 40 tids from 0, alternating sources.
        fire_q.delete();
        for (int t = 0; t < 40; t++) expect_t(t & 15, 6 + t / 16);
        a = 0;
        for (int t = 0; t < 40; t++) begin
            send(t % 2, t & 15, 6 + t / 16);
            if (t == 0) a = last_acc;
        end
        drain();
        chk_fires("wrap", a + LAT, 40);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
